// File: rtl/keysw_io_pkg.sv
// Shared constants, status flag type and helpers for the KEY/SW memory-mapped input device.
package keysw_io_pkg;

  localparam int KEY_W     = 4;
  localparam int SW_W      = 10;
  localparam int READY_BIT = 0;
  localparam int OVR_BIT   = 2;

  localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
  localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
  localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;

  typedef struct packed {
    logic ovr;
    logic ready;
  } status_t;

  // A new event always claims ready; overrun is set only if an unread event is being lost.
  function automatic status_t status_next(input status_t cur, input logic change,
                                          input logic data_rd, input logic ovr_clr);
    status_t nxt;
    nxt.ready = change | (cur.ready & ~data_rd);
    nxt.ovr   = (change & cur.ready & ~data_rd) | (cur.ovr & ~ovr_clr);
    return nxt;
  endfunction

  function automatic logic [31:0] ctrl_word(input status_t s);
    logic [31:0] w;
    w            = 32'h0000_0000;
    w[READY_BIT] = s.ready;
    w[OVR_BIT]   = s.ovr;
    return w;
  endfunction

endpackage

// File: rtl/keysw_io_device_debouncer.sv
// Two-flop synchronizer plus per-bit saturating debounce counters and stable register.
module input_debouncer
  import keysw_io_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] SYNC_RST        = {WIDTH{1'b0}},
  parameter bit               INVERT          = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic             changed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] synced_s;
  logic [WIDTH-1:0] update_s;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // synchronizer next state and polarity normalisation
  always_comb begin
    sync1_d  = din;
    sync2_d  = sync1_q;
    synced_s = sync2_q ^ {WIDTH{INVERT}};
  end

  // per-bit debounce: count consecutive disagreeing cycles, accept on the last one
  always_comb begin
    stable_d = stable_q;
    update_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (synced_s[i] == stable_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] >= CNT_LAST) begin
        cnt_d[i]    = {CNT_W{1'b0}};
        stable_d[i] = synced_s[i];
        update_s[i] = 1'b1;
      end else if (cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= SYNC_RST;
      sync2_q  <= SYNC_RST;
      stable_q <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign stable  = stable_q;
  assign changed = |update_s;

endmodule

// File: rtl/keysw_io_device.sv
// KEY/SW memory-mapped input device: debounced data registers, sticky ready/overrun, read mux.
module keysw_io_device
  import keysw_io_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDRKEY         = DBITS'(ADDR_KEY),
  parameter logic [DBITS-1:0] ADDRSW          = DBITS'(ADDR_SW),
  parameter logic [DBITS-1:0] ADDRKCTRL       = DBITS'(ADDR_KCTRL),
  parameter logic [DBITS-1:0] ADDRSCTRL       = DBITS'(ADDR_SCTRL),
  parameter int               DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_n,
  input  logic [SW_W-1:0]  sw,
  input  logic [DBITS-1:0] addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wdata,
  output logic             sel,
  output logic [DBITS-1:0] rdata
);

  logic [KEY_W-1:0] kstable_s;
  logic [SW_W-1:0]  sstable_s;
  logic             kchanged_s, schanged_s;
  logic             kread_s, sread_s, kclr_s, sclr_s;
  status_t          kstat_q, kstat_d, sstat_q, sstat_d;
  logic             unused_wdata_s;

  input_debouncer #(
    .WIDTH(KEY_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_RST({KEY_W{1'b1}}), .INVERT(1'b1)
  ) u_key_db (
    .clk(clk), .reset(reset), .din(key_n), .stable(kstable_s), .changed(kchanged_s)
  );

  input_debouncer #(
    .WIDTH(SW_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_RST({SW_W{1'b0}}), .INVERT(1'b0)
  ) u_sw_db (
    .clk(clk), .reset(reset), .din(sw), .stable(sstable_s), .changed(schanged_s)
  );

  // bus side effects: data reads consume ready, a written 0 in the overrun bit clears it
  always_comb begin
    kread_s = rd_en & (addr == ADDRKEY);
    sread_s = rd_en & (addr == ADDRSW);
    kclr_s  = wr_en & (addr == ADDRKCTRL) & ~wdata[OVR_BIT];
    sclr_s  = wr_en & (addr == ADDRSCTRL) & ~wdata[OVR_BIT];
    kstat_d = status_next(kstat_q, kchanged_s, kread_s, kclr_s);
    sstat_d = status_next(sstat_q, schanged_s, sread_s, sclr_s);
  end

  // status flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kstat_q <= '{ovr: 1'b0, ready: 1'b0};
      sstat_q <= '{ovr: 1'b0, ready: 1'b0};
    end else begin
      kstat_q <= kstat_d;
      sstat_q <= sstat_d;
    end
  end

  // address decode and read mux; CTRL words reflect pre-edge flag values
  always_comb begin
    sel   = 1'b1;
    rdata = {DBITS{1'b0}};
    case (addr)
      ADDRKEY:   rdata = DBITS'(kstable_s);
      ADDRSW:    rdata = DBITS'(sstable_s);
      ADDRKCTRL: rdata = DBITS'(ctrl_word(kstat_q));
      ADDRSCTRL: rdata = DBITS'(ctrl_word(sstat_q));
      default: begin
        sel   = 1'b0;
        rdata = {DBITS{1'b0}};
      end
    endcase
  end

  assign unused_wdata_s = ^{wdata[DBITS-1:OVR_BIT+1], wdata[OVR_BIT-1:0]};

endmodule

// File: tb/tb_keysw_io_device.sv
// Directed test-plan scenarios plus random traffic, checked against a window-based reference model.
module tb_keysw_io_device;

  localparam int D = 4;
  localparam logic [31:0] A_KEY   = 32'hF000_0010;
  localparam logic [31:0] A_SW    = 32'hF000_0014;
  localparam logic [31:0] A_KCTRL = 32'hF000_0110;
  localparam logic [31:0] A_SCTRL = 32'hF000_0114;
  localparam logic [31:0] A_OTHER = 32'hF000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  key_n = 4'hF;
  logic [9:0]  sw = 10'h000;
  logic [31:0] addr = 32'h0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        sel;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  keysw_io_device #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw(sw), .addr(addr),
    .rd_en(rd_en), .wr_en(wr_en), .wdata(wdata), .sel(sel), .rdata(rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: group 0 = KEY (pressed = 1), group 1 = SW.
  // A stable bit flips once the last D synchronized samples all disagree with it.
  logic [9:0] m_s1 [2];
  logic [9:0] m_s2 [2];
  logic [9:0] m_st [2];
  logic [9:0] m_hist [2][D];
  int         m_hn [2];
  bit         m_ready [2];
  bit         m_ovr [2];

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      m_s1[g] = 10'h0; m_s2[g] = 10'h0; m_st[g] = 10'h0;
      m_hn[g] = 0; m_ready[g] = 1'b0; m_ovr[g] = 1'b0;
    end
  endtask

  function automatic logic exp_sel(input logic [31:0] a);
    return (a == A_KEY) || (a == A_SW) || (a == A_KCTRL) || (a == A_SCTRL);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (a == A_KEY)   return {22'h0, m_st[0]};
    if (a == A_SW)    return {22'h0, m_st[1]};
    if (a == A_KCTRL) return {29'h0, m_ovr[0], 1'b0, m_ready[0]};
    if (a == A_SCTRL) return {29'h0, m_ovr[1], 1'b0, m_ready[1]};
    return 32'h0;
  endfunction

  task automatic model_edge(input logic [3:0] kn, input logic [9:0] s, input logic [31:0] a,
                            input logic r, input logic w, input logic [31:0] wd);
    logic [9:0] nst;
    bit all_diff, chg, rd_hit, clr_hit;
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < D - 1; i++) m_hist[g][i] = m_hist[g][i+1];
      m_hist[g][D-1] = m_s2[g];
      if (m_hn[g] < D) m_hn[g]++;
      nst = m_st[g];
      if (m_hn[g] == D) begin
        for (int b = 0; b < 10; b++) begin
          all_diff = 1'b1;
          for (int i = 0; i < D; i++) if (m_hist[g][i][b] == m_st[g][b]) all_diff = 1'b0;
          if (all_diff) nst[b] = ~m_st[g][b];
        end
      end
      chg     = (nst != m_st[g]);
      rd_hit  = r && (a == ((g == 0) ? A_KEY : A_SW));
      clr_hit = w && (a == ((g == 0) ? A_KCTRL : A_SCTRL)) && !wd[2];
      m_ovr[g]   = (chg && m_ready[g] && !rd_hit) || (m_ovr[g] && !clr_hit);
      m_ready[g] = chg || (m_ready[g] && !rd_hit);
      m_st[g] = nst;
      m_s2[g] = m_s1[g];
      m_s1[g] = (g == 0) ? {6'h0, ~kn} : s;
    end
  endtask

  logic [3:0]  cur_kn = 4'hF;
  logic [9:0]  cur_sw = 10'h000;
  logic [31:0] last_rdata;
  logic        last_sel;

  task automatic cyc(input logic [31:0] a, input logic r, input logic w, input logic [31:0] wd);
    @(negedge clk);
    reset = 1'b0;
    key_n = cur_kn; sw = cur_sw; addr = a; rd_en = r; wr_en = w; wdata = wd;
    #1;
    last_rdata = rdata;
    last_sel   = sel;
    check_val("sel", {31'h0, sel}, {31'h0, exp_sel(a)});
    check_val($sformatf("rdata@%h", a), rdata, exp_rdata(a));
    model_edge(cur_kn, cur_sw, a, r, w, wd);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(A_OTHER, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag);
    cyc(a, 1'b0, 1'b0, 32'h0);
    check_val(tag, last_rdata, exp);
  endtask

  // Leaves reset high across two edges; the next cyc releases it.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; addr = A_SW; rd_en = 1'b0; wr_en = 1'b0;
    model_reset();
    #1;
    check_val("rst_sdata", rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    addr = A_KCTRL;
    #1;
    check_val("rst_kctrl", rdata, 32'h0);
    @(posedge clk);
  endtask

  initial begin
    model_reset();
    cur_kn = 4'hF; cur_sw = 10'h000;
    do_reset();
    peek(A_KEY, 32'h0, "reset_kdata");
    peek(A_KCTRL, 32'h0, "reset_kctrl");
    peek(A_KEY, 32'h0, "reset_kdata2");
    check_val("sel_at_key", {31'h0, last_sel}, 32'h1);
    peek(A_OTHER, 32'h0, "unmapped_rdata");
    check_val("sel_unmapped", {31'h0, last_sel}, 32'h0);

    cur_kn = 4'hE;
    idle(5);
    peek(A_KCTRL, 32'h0, "kctrl_before_6");
    peek(A_KCTRL, 32'h1, "kctrl_at_6");
    peek(A_KEY, 32'h1, "kdata_pressed");
    cyc(A_KEY, 1'b1, 1'b0, 32'h0);
    peek(A_KCTRL, 32'h0, "kctrl_after_read");

    cur_sw = 10'h008;
    idle(3);
    cur_sw = 10'h000;
    idle(8);
    peek(A_SW, 32'h0, "glitch_sdata");
    peek(A_SCTRL, 32'h0, "glitch_sctrl");
    cur_sw = 10'h208;
    idle(6);
    peek(A_SW, 32'h208, "sdata_208");

    cur_sw = 10'h000;
    idle(6);
    peek(A_SCTRL, 32'h5, "sctrl_overrun");
    cyc(A_SCTRL, 1'b0, 1'b1, 32'h0);
    peek(A_SCTRL, 32'h1, "sctrl_ovr_cleared");
    cyc(A_SCTRL, 1'b0, 1'b1, 32'h4);
    peek(A_SCTRL, 32'h1, "sctrl_write1_ignored");

    cur_kn = 4'hC;
    idle(6);
    peek(A_KCTRL, 32'h1, "kctrl_ready_again");
    cur_kn = 4'h8;
    idle(5);
    cyc(A_KEY, 1'b1, 1'b0, 32'h0);
    check_val("kdata_preclear", last_rdata, 32'h3);
    peek(A_KCTRL, 32'h1, "event_beats_read");
    peek(A_KEY, 32'h7, "kdata_7");
    cur_kn = 4'h0;
    idle(5);
    cyc(A_KCTRL, 1'b0, 1'b1, 32'h0);
    check_val("kctrl_old_on_event", last_rdata, 32'h1);
    peek(A_KCTRL, 32'h5, "set_beats_clear");

    cur_sw = 10'h3FF;
    idle(2);
    do_reset();
    idle(5);
    peek(A_SCTRL, 32'h0, "post_reset_before_6");
    peek(A_SCTRL, 32'h1, "post_reset_event");
    peek(A_SW, 32'h3FF, "post_reset_sdata");

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      int pick;
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) cur_kn = 4'($urandom_range(0, 15));
        else cur_kn[$urandom_range(0, 3)] = ~cur_kn[$urandom_range(0, 3)];
      end
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) cur_sw = 10'($urandom_range(0, 1023));
        else cur_sw[$urandom_range(0, 9)] = ~cur_sw[$urandom_range(0, 9)];
      end
      pick = $urandom_range(0, 5);
      case (pick)
        0: a = A_KEY;
        1: a = A_SW;
        2: a = A_KCTRL;
        3: a = A_SCTRL;
        4: a = A_OTHER;
        default: a = 32'($urandom);
      endcase
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc(a, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 32'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
